// File: rtl/data_mem_responder.sv
// data_mem_responder: word RAM behind a valid/ready request/response port with fixed wait states.
// Optional MISALIGN_CHECK_EN flags misaligned accesses with resp_err and suppresses their writes.
module data_mem_responder #(
    parameter int RAM_SIZE     = 256,
    parameter int RAM_SIZE_BIT = 8,
    parameter int WAIT_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam bit NO_WAIT = WAIT_CYCLES == 0;
    state_t state, state_next;
    logic [3:0] cnt;
    logic [31:0] mem [RAM_SIZE];
    logic lat_write;
    logic [RAM_SIZE_BIT-1:0] lat_idx;
    logic [31:0] lat_wdata;
    logic accept, access, acc_write, acc_mis;
    logic [RAM_SIZE_BIT-1:0] acc_idx;
    logic [31:0] acc_wdata;
    logic unused_bits;
    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign accept     = req_ready && req_valid;
    // With no wait states the access uses the live request, since latching happens on the same edge.
    assign access     = NO_WAIT ? accept : (state == WAIT && cnt == 4'd1);
    assign acc_write  = NO_WAIT ? req_write : lat_write;
    assign acc_idx    = NO_WAIT ? req_addr[RAM_SIZE_BIT+1:2] : lat_idx;
    assign acc_wdata  = NO_WAIT ? req_wdata : lat_wdata;
`ifdef MISALIGN_CHECK_EN
    logic [1:0] lat_off;
    assign acc_mis     = (NO_WAIT ? req_addr[1:0] : lat_off) != 2'd0;
    assign unused_bits = ^req_addr[31:RAM_SIZE_BIT+2];
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) lat_off <= 2'd0;
        else if (accept) lat_off <= req_addr[1:0];
    end
`else
    assign acc_mis     = 1'b0;
    assign unused_bits = ^{req_addr[31:RAM_SIZE_BIT+2], req_addr[1:0]};
`endif
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = req_valid ? (NO_WAIT ? RESP : WAIT) : IDLE;
            WAIT:    state_next = cnt == 4'd1 ? RESP : WAIT;
            RESP:    state_next = resp_ready ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            lat_write  <= 1'b0;
            lat_idx    <= '0;
            lat_wdata  <= 32'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt       <= 4'(WAIT_CYCLES);
                lat_write <= req_write;
                lat_idx   <= req_addr[RAM_SIZE_BIT+1:2];
                lat_wdata <= req_wdata;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                resp_rdata <= (acc_write || acc_mis) ? 32'd0 : mem[acc_idx];
                resp_err   <= acc_mis;
            end else if (state == RESP && resp_ready) begin
                resp_rdata <= 32'd0;
                resp_err   <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < RAM_SIZE; i++) mem[i] <= 32'd5;
        end else if (access && acc_write && !acc_mis) begin
            mem[acc_idx] <= acc_wdata;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vectors on a 2-wait-state instance plus a zero-wait instance.
module tb_data_mem_responder;
    logic clk = 0, Reset = 1;
    logic vld = 0, rdy = 0, sel = 1;
    logic req_write = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic rr2, rv2, re2, rr0, rv0, re0;
    logic [31:0] rd2, rd0;
    logic rr, rv, re;
    logic [31:0] rdat;
    int errors = 0, checks = 0;
    always #5 clk = ~clk;
    assign rr   = sel ? rr2 : rr0;
    assign rv   = sel ? rv2 : rv0;
    assign re   = sel ? re2 : re0;
    assign rdat = sel ? rd2 : rd0;
    data_mem_responder #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .Reset(Reset), .req_valid(vld & sel), .req_ready(rr2),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv2), .resp_ready(rdy & sel), .resp_rdata(rd2), .resp_err(re2));
    data_mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .Reset(Reset), .req_valid(vld & ~sel), .req_ready(rr0),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv0), .resp_ready(rdy & ~sel), .resp_rdata(rd0), .resp_err(re0));
    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        er;
    } vec_t;
    vec_t v[7];
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int hold, input bit poke,
                       output logic [31:0] rd, output logic er);
        int lat;
        @(negedge clk);
        chk("req_ready before request", 32'(rr), 1);
        vld = 1; req_write = w; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        vld = 0;
        lat = 0;
        while (!rv && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, sel ? 2 : 0);
        rd = rdat;
        er = re;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (poke) begin
                vld = 1; req_write = 1; req_wdata = 32'h99;
            end
            @(posedge clk); #1;
            chk("stall resp_valid", 32'(rv), 1);
            chk("stall resp_rdata", rdat, rd);
            chk("stall req_ready", 32'(rr), 0);
        end
        @(negedge clk);
        vld = 0; rdy = 1;
        @(posedge clk); #1;
        rdy = 0;
        chk("release resp_valid", 32'(rv), 0);
        chk("release resp_rdata", rdat, 0);
        chk("release resp_err", 32'(re), 0);
        chk("release req_ready", 32'(rr), 1);
    endtask
    initial begin
        logic [31:0] rd;
        logic er;
        v[0] = '{0, 32'h40,       32'h0,        32'h5,        0};
        v[1] = '{1, 32'h14,       32'h3C,       32'h0,        0};
        v[2] = '{0, 32'h14,       32'h0,        32'h3C,       0};
        v[3] = '{1, 32'h10000020, 32'hDEADBEEF, 32'h0,        0};
        v[4] = '{0, 32'h20,       32'h0,        32'hDEADBEEF, 0};
        v[5] = '{0, 32'h420,      32'h0,        32'hDEADBEEF, 0};
        v[6] = '{0, 32'h3FC,      32'h0,        32'h5,        0};
        #1;
        chk("reset resp_valid", 32'(rv2), 0);
        chk("reset req_ready", 32'(rr2), 1);
        chk("reset resp_rdata", rd2, 0);
        chk("reset resp_err", 32'(re2), 0);
        @(negedge clk); @(negedge clk);
        Reset = 0;
        for (int i = 0; i < 7; i++) begin
            txn(v[i].w, v[i].a, v[i].d, 0, 0, rd, er);
            chk($sformatf("vec%0d rdata", i), rd, v[i].rd);
            chk($sformatf("vec%0d err", i), 32'(er), 32'(v[i].er));
        end
        txn(0, 32'h14, 0, 5, 1, rd, er);
        chk("stalled load rdata", rd, 32'h3C);
        txn(0, 32'h14, 0, 0, 0, rd, er);
        chk("ignored store left data", rd, 32'h3C);
        @(negedge clk);
        vld = 1; req_write = 1; req_addr = 32'h08; req_wdata = 32'h77;
        @(posedge clk); #1;
        vld = 0;
        @(negedge clk);
        Reset = 1;
        #1;
        chk("abort resp_valid", 32'(rv2), 0);
        chk("abort req_ready", 32'(rr2), 1);
        chk("abort resp_rdata", rd2, 0);
        @(negedge clk); @(negedge clk);
        Reset = 0;
        txn(0, 32'h08, 0, 0, 0, rd, er);
        chk("aborted store not written", rd, 32'h5);
        txn(0, 32'h14, 0, 0, 0, rd, er);
        chk("reset reloads memory", rd, 32'h5);
        txn(1, 32'h402, 32'h55, 0, 0, rd, er);
        chk("misaligned store rdata", rd, 0);
`ifdef MISALIGN_CHECK_EN
        chk("misaligned store err", 32'(er), 1);
        txn(0, 32'h400, 0, 0, 0, rd, er);
        chk("misaligned store not written", rd, 32'h5);
`else
        chk("misaligned store err", 32'(er), 0);
        txn(0, 32'h400, 0, 0, 0, rd, er);
        chk("unaligned store written", rd, 32'h55);
`endif
        chk("aligned load err", 32'(er), 0);
        sel = 0;
        txn(0, 32'h0, 0, 0, 0, rd, er);
        chk("zero-wait load rdata", rd, 32'h5);
        txn(1, 32'h400, 32'hABCD, 0, 0, rd, er);
        chk("zero-wait store rdata", rd, 0);
        txn(0, 32'h0, 0, 2, 0, rd, er);
        chk("zero-wait alias load", rd, 32'hABCD);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- RAM_SIZE, 256, number of 32-bit words.
- RAM_SIZE_BIT, 8, word-index width; log2(RAM_SIZE).
- WAIT_CYCLES, 2, wait states between request acceptance and memory access; range 0..15.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, clock; all state changes on posedge.
- Reset, in, 1, reset; asynchronous, active-high.
- req_valid, in, 1, initiator presents a request.
- req_ready, out, 1, responder can accept a request.
- req_write, in, 1, 1 = store, 0 = load.
- req_addr, in, 32, byte address.
- req_wdata, in, 32, store data.
- resp_valid, out, 1, response available.
- resp_ready, in, 1, initiator consumes the response.
- resp_rdata, out, 32, load data; 0 for stores.
- resp_err, out, 1, misaligned-access flag.

Function
REQ-003 The block SHALL hold RAM_SIZE 32-bit words, indexed by req_addr[RAM_SIZE_BIT+1:2]; higher address bits are ignored, so addresses wrap.
REQ-004 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-005 req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
REQ-006 A request SHALL be accepted at a posedge where req_valid=1 and req_ready=1.
- On acceptance, req_write, the word index, req_addr[1:0] and req_wdata SHALL be latched.
- Request inputs SHALL be ignored at every other edge.
REQ-007 On acceptance with WAIT_CYCLES>0, the FSM SHALL go to WAIT and load the down-counter with WAIT_CYCLES.
REQ-008 In WAIT, the counter SHALL decrement each edge.
- At the edge where the counter equals 1, the FSM SHALL perform the access and go to RESP.
REQ-009 With WAIT_CYCLES=0, acceptance SHALL perform the access and go directly to RESP at the same edge.
REQ-010 Latency: for a request accepted at edge k, the memory access SHALL occur at edge k+WAIT_CYCLES.
- resp_valid SHALL be 1 from just after edge k+WAIT_CYCLES.
REQ-011 Access for a store SHALL write the latched data to the latched index and set resp_rdata=0.
REQ-012 Access for a load SHALL register the addressed word into resp_rdata.
REQ-013 In RESP, resp_valid, resp_rdata and resp_err SHALL stay stable until an edge with resp_ready=1.
- At that edge the FSM SHALL return to IDLE and clear resp_rdata and resp_err to 0.
- req_ready SHALL rise in the following cycle; there is no same-edge re-acceptance.
REQ-014 req_valid asserted outside IDLE SHALL have no effect.
- The initiator holds the request until req_ready=1.
REQ-015 A load following a store to the same index SHALL return the stored data.
REQ-016 Memory contents SHALL change only on store accesses and on Reset.

Reset
REQ-017 Reset=1 SHALL, asynchronously, force the FSM to IDLE and the counter to 0.
- It SHALL clear resp_valid, resp_rdata and resp_err to 0, with req_ready=1.
- It SHALL load every memory word with 32'd5.
REQ-018 Reset during WAIT or RESP SHALL abort the transaction.
- An aborted store whose access edge has not occurred SHALL NOT be written.

Configuration
REQ-019 Macro MISALIGN_CHECK_EN defined:
- An accepted request with latched addr[1:0]!=0 SHALL still take the full WAIT_CYCLES latency.
- At the access edge, a misaligned store SHALL perform no write.
- The response SHALL carry resp_err=1 and resp_rdata=0.
REQ-020 MISALIGN_CHECK_EN undefined:
- addr[1:0] SHALL be ignored.
- resp_err SHALL be tied to 0.

Verification
REQ-021 The bench SHALL cover, with WAIT_CYCLES=2 unless stated:
- Reset, then load from addr 0x40 -> resp_valid is 1 two edges after acceptance, with resp_rdata=5.
- Store 0x0000003C to addr 0x14, then load from 0x14 -> load returns 0x0000003C; the store response has resp_rdata=0.
- Load with resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stay stable; req_ready stays 0; a concurrent req_valid is ignored.
- Reset asserted during WAIT of a store to 0x08 -> outputs cleared immediately; a later load of 0x08 returns 5.
- Store 0x55 to addr 0x402 with MISALIGN_CHECK_EN -> resp_err=1 and no write; without the macro, a load of 0x400 returns 0x55.
- WAIT_CYCLES=0, load from addr 0 -> resp_valid is 1 right after the accepting edge; index wrap confirmed (addr 0x400 aliases addr 0).
